// File: rtl/gpi_ctrl.sv
`timescale 1ns/1ps
// gpi_ctrl: memory-mapped general-purpose input block: 2-FF pin synchronizer, per-pin edge capture
// into write-1-to-clear pending flags, level irq. Define GPI_DEBOUNCE_EN to add per-pin debounce counters.
module gpi_ctrl #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 16 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("gpi_ctrl: WIDTH must be 1..16 and DEBOUNCE_CYCLES at least 1");
  end

  localparam logic [1:0] ADDR_IDR = 2'd0;
  localparam logic [1:0] ADDR_IER = 2'd1;
  localparam logic [1:0] ADDR_ISR = 2'd2;
  localparam logic [1:0] ADDR_ECR = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] idr_q,      idr_d;
  logic [WIDTH-1:0] ier_q,      ier_d;
  logic [WIDTH-1:0] isr_q,      isr_d;
  logic [WIDTH-1:0] ecr_rise_q, ecr_rise_d;
  logic [WIDTH-1:0] ecr_fall_q, ecr_fall_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_rise;
  logic [WIDTH-1:0] edge_fall;
  logic [WIDTH-1:0] isr_set;
  logic [WIDTH-1:0] isr_clr;

  assign wr_en = cs & wr;

  // Only sync2_q may be consumed by the rest of the block; sync1_q can go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpi;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPI_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A pin is accepted once it has disagreed with IDR for DEBOUNCE_CYCLES counted cycles.
  always_comb begin
    idr_d = idr_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != idr_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          idr_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    idr_d = sync2_q;
  end
`endif

  always_comb begin
    edge_rise = idr_d & ~idr_q;
    edge_fall = ~idr_d & idr_q;
    isr_set   = (edge_rise & ecr_rise_q) | (edge_fall & ecr_fall_q);
  end

  always_comb begin
    ier_d      = ier_q;
    ecr_rise_d = ecr_rise_q;
    ecr_fall_d = ecr_fall_q;
    isr_clr    = '0;
    if (wr_en) begin
      unique case (addr)
        ADDR_IER: ier_d = wdata[WIDTH-1:0];
        ADDR_ISR: isr_clr = wdata[WIDTH-1:0];
        ADDR_ECR: begin
          ecr_rise_d = wdata[WIDTH-1:0];
          ecr_fall_d = wdata[16 +: WIDTH];
        end
        default: ;
      endcase
    end
    // A new edge outranks a same-cycle clear of that bit.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idr_q      <= '0;
      ier_q      <= '0;
      isr_q      <= '0;
      ecr_rise_q <= '0;
      ecr_fall_q <= '0;
    end else begin
      idr_q      <= idr_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      ecr_rise_q <= ecr_rise_d;
      ecr_fall_q <= ecr_fall_d;
    end
  end

  assign irq = |(isr_q & ier_q);

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_IDR: rdata[WIDTH-1:0] = idr_q;
      ADDR_IER: rdata[WIDTH-1:0] = ier_q;
      ADDR_ISR: rdata[WIDTH-1:0] = isr_q;
      ADDR_ECR: begin
        rdata[WIDTH-1:0]  = ecr_rise_q;
        rdata[16 +: WIDTH] = ecr_fall_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpi_ctrl.sv
`timescale 1ns/1ps
// tb_gpi_ctrl: vector table, directed multi-cycle sequences and a randomized run against a queue-based model.
module tb_gpi_ctrl;

  localparam int W = 16;
`ifdef GPI_DEBOUNCE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          cs    = 1'b0;
  logic          wr    = 1'b0;
  logic [1:0]    addr  = 2'd0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [W-1:0]  gpi   = '0;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  gpi_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .gpi   (gpi),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic [15:0] gpi;
    logic        do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          settle;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cs = 1'b0; wr = 1'b0; gpi = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Model state for the randomized run
  logic [15:0] hist[$];
  logic [15:0] m_idr, m_ier, m_isr, m_rise, m_fall;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0, m_idr};
      2'd1:    return {16'h0, m_ier};
      2'd2:    return {16'h0, m_isr};
      default: return {m_fall, m_rise};
    endcase
  endfunction

  initial begin
    // reset state
    #5;
    check("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) check_reg("rst_reg", 2'(a), 32'h0);
    do_reset();

    // table: name, gpi, do_wr, waddr, wdata, settle, raddr, exp_rd, exp_irq
    vecs.push_back('{"ier_wr",        16'h0000, 1'b1, 2'd1, 32'h0000_0001, 0,  2'd1, 32'h0000_0001, 1'b0});
    vecs.push_back('{"ecr_wr",        16'h0000, 1'b1, 2'd3, 32'h0000_0001, 0,  2'd3, 32'h0000_0001, 1'b0});
    vecs.push_back('{"rise0_idr",     16'h0001, 1'b0, 2'd0, 32'h0,         14, 2'd0, 32'h0000_0001, 1'b1});
    vecs.push_back('{"rise0_isr",     16'h0001, 1'b0, 2'd0, 32'h0,         0,  2'd2, 32'h0000_0001, 1'b1});
    vecs.push_back('{"isr_w0",        16'h0001, 1'b1, 2'd2, 32'h0000_0000, 0,  2'd2, 32'h0000_0001, 1'b1});
    vecs.push_back('{"isr_w1c",       16'h0001, 1'b1, 2'd2, 32'h0000_0001, 0,  2'd2, 32'h0000_0000, 1'b0});
    vecs.push_back('{"idr_ro",        16'h0001, 1'b1, 2'd0, 32'hFFFF_FFFF, 0,  2'd0, 32'h0000_0001, 1'b0});
    vecs.push_back('{"fall1_en_rise", 16'h0003, 1'b1, 2'd3, 32'h0002_0000, 14, 2'd2, 32'h0000_0000, 1'b0});
    vecs.push_back('{"fall1_isr",     16'h0001, 1'b0, 2'd0, 32'h0,         14, 2'd2, 32'h0000_0002, 1'b0});
    vecs.push_back('{"pin2_rise_off", 16'h0005, 1'b0, 2'd0, 32'h0,         14, 2'd2, 32'h0000_0002, 1'b0});
    vecs.push_back('{"pin2_fall_off", 16'h0001, 1'b0, 2'd0, 32'h0,         14, 2'd2, 32'h0000_0002, 1'b0});
    vecs.push_back('{"ier_gate_on",   16'h0001, 1'b1, 2'd1, 32'h0000_0002, 0,  2'd1, 32'h0000_0002, 1'b1});
    vecs.push_back('{"isr_clr1",      16'h0001, 1'b1, 2'd2, 32'h0000_0002, 0,  2'd2, 32'h0000_0000, 1'b0});
    vecs.push_back('{"ier_upper0",    16'h0001, 1'b1, 2'd1, 32'hFFFF_FFFF, 0,  2'd1, 32'h0000_FFFF, 1'b0});
    vecs.push_back('{"ecr_full",      16'h0001, 1'b1, 2'd3, 32'hFFFF_FFFF, 0,  2'd3, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"idr_hold",      16'h0001, 1'b0, 2'd0, 32'h0,         4,  2'd0, 32'h0000_0001, 1'b0});

    foreach (vecs[i]) begin
      gpi = vecs[i].gpi;
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      else tick(1);
      tick(vecs[i].settle);
      check_reg(vecs[i].name, vecs[i].raddr, vecs[i].exp_rd);
      check({vecs[i].name, "_irq"}, {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // exact rising-edge latency and W1C
    do_reset();
    bus_write(2'd3, 32'h0000_0001);
    bus_write(2'd1, 32'h0000_0001);
    gpi = 16'h0001;
    tick(LAT - 1);
    check_reg("lat_idr_early", 2'd0, 32'h0);
    check_reg("lat_isr_early", 2'd2, 32'h0);
    tick(1);
    check_reg("lat_idr", 2'd0, 32'h1);
    check_reg("lat_isr", 2'd2, 32'h1);
    check("lat_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h0000_0001);
    check_reg("lat_isr_clr", 2'd2, 32'h0);
    check("lat_irq_clr", {31'b0, irq}, 32'h0);

    // set/clear collision on pin 3, pin 4 clears normally
    do_reset();
    bus_write(2'd3, 32'h0000_0018);
    gpi = 16'h0010;
    tick(LAT + 2);
    check_reg("col_pre", 2'd2, 32'h10);
    gpi = 16'h0018;
    tick(LAT - 1);
    bus_write(2'd2, 32'h0000_0018);
    check_reg("col_isr", 2'd2, 32'h08);
    bus_write(2'd2, 32'h0000_0008);
    check_reg("col_isr_clr", 2'd2, 32'h0);

    // IER gating
    do_reset();
    bus_write(2'd3, 32'h0000_0010);
    gpi = 16'h0010;
    tick(LAT + 2);
    check_reg("gate_isr", 2'd2, 32'h10);
    check("gate_irq_off", {31'b0, irq}, 32'h0);
    bus_write(2'd1, 32'h0000_0010);
    check("gate_irq_on", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h0000_0000);
    check_reg("gate_isr_w0", 2'd2, 32'h10);
    check("gate_irq_hold", {31'b0, irq}, 32'h1);

    // asynchronous reset mid-run
    do_reset();
    bus_write(2'd3, 32'h0000_0005);
    bus_write(2'd1, 32'h0000_FFFF);
    gpi = 16'h0005;
    tick(LAT + 2);
    check_reg("arst_pre_isr", 2'd2, 32'h5);
    check("arst_pre_irq", {31'b0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1 check("arst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) check_reg("arst_reg", 2'(a), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(LAT - 1);
    check_reg("arst_idr_early", 2'd0, 32'h0);
    tick(1);
    check_reg("arst_idr_track", 2'd0, 32'h5);
    gpi = 16'h0003;
    tick(LAT + 1);
    check_reg("arst_idr_track2", 2'd0, 32'h3);

`ifdef GPI_DEBOUNCE_EN
    do_reset();
    bus_write(2'd3, 32'h0000_0001);
    bus_write(2'd1, 32'h0000_0001);
    gpi = 16'h0001;
    tick(5);
    gpi = 16'h0000;
    tick(20);
    check_reg("db_glitch_idr", 2'd0, 32'h0);
    check_reg("db_glitch_isr", 2'd2, 32'h0);
    check("db_glitch_irq", {31'b0, irq}, 32'h0);
    gpi = 16'h0001;
    tick(10);
    check_reg("db_idr_early", 2'd0, 32'h0);
    tick(1);
    check_reg("db_idr", 2'd0, 32'h1);
    check_reg("db_isr", 2'd2, 32'h1);
    tick(9);
    gpi = 16'h0000;
    tick(2);
`else
    // randomized run against a delay-queue model
    do_reset();
    hist.delete();
    hist.push_back(16'h0);
    hist.push_back(16'h0);
    m_idr = '0; m_ier = '0; m_isr = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < 400; c++) begin
      logic [15:0] nidr, clr, setm;
      int op;
      if ($urandom_range(0, 2) == 0)
        gpi = gpi ^ (16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535)));
      op = $urandom_range(0, 7);
      cs = 1'b0; wr = 1'b0;
      case (op)
        0: begin cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = $urandom; end
        1: begin cs = 1'b1; wr = 1'b1; addr = 2'd1; wdata = $urandom; end
        2: begin cs = 1'b1; wr = 1'b1; addr = 2'd3; wdata = $urandom; end
        3: begin cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = $urandom; end
        4: begin cs = 1'b0; wr = 1'b1; addr = 2'($urandom_range(1, 3)); wdata = $urandom; end
        default: ;
      endcase
      hist.push_back(gpi);
      @(negedge clk);
      nidr = hist[hist.size() - 3];
      setm = (nidr & ~m_idr & m_rise) | (~nidr & m_idr & m_fall);
      clr  = (cs && wr && addr == 2'd2) ? wdata[15:0] : 16'h0;
      m_isr = (m_isr & ~clr) | setm;
      if (cs && wr && addr == 2'd1) m_ier = wdata[15:0];
      if (cs && wr && addr == 2'd3) begin
        m_rise = wdata[15:0];
        m_fall = wdata[31:16];
      end
      m_idr = nidr;
      cs = 1'b0; wr = 1'b0;
      addr = 2'($urandom_range(0, 3));
      #1;
      check("rand_rd", rdata, m_read(addr));
      check("rand_irq", {31'b0, irq}, {31'b0, |(m_isr & m_ier)});
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
